mod_inv_bin: RTL and testbench

//  Parametrised modular-inverse engine. Computes inv = a^-1 mod p for any odd modulus p
//  (WIDTH bits) using the binary extended Euclidean algorithm, one step per clock.

---
 rtl/mod_inv_bin.sv | 197 +++++++++++++++++++
 tb/tb_mod_inv_bin.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_inv_bin.sv
// Modular inverse a^-1 mod p for odd p via the binary extended Euclidean algorithm,
// one reduction step per clock, with operand checks, error codes and a step counter.
module mod_inv_bin #(
    parameter int WIDTH     = 256,
    parameter int MAX_STEPS = 4*WIDTH+4,
    parameter int CNT_W     = $clog2(MAX_STEPS+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] p,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] inv,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] steps
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] pr_q, pr_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] x2_q, x2_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] inv_q, inv_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] steps_q, steps_d;

    // x/2 mod m for odd m: an odd x is lifted by m first, using one extra carry bit.
    function automatic logic [WIDTH-1:0] halve_mod(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] m);
        logic [WIDTH:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return s[WIDTH:1];
    endfunction

    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (x < y) begin
            d = d + {1'b0, m};
        end
        return d[WIDTH-1:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        start_d    = start;
        u_d        = u_q;
        v_d        = v_q;
        pr_d       = pr_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        inv_d      = inv_q;
        err_code_d = err_code_q;
        steps_d    = steps_q;

        case (state_q)
            S_IDLE: begin
                if (start && !start_q) begin
                    u_d     = a;
                    v_d     = p;
                    pr_d    = p;
                    x1_d    = WIDTH'(1);
                    x2_d    = '0;
                    steps_d = '0;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (!pr_q[0] || (pr_q < WIDTH'(3))) begin
                    state_d    = S_FIN;
                    error_d    = 1'b1;
                    err_code_d = 2'd2;
                    inv_d      = '0;
                end else if ((u_q == '0) || (u_q >= pr_q)) begin
                    state_d    = S_FIN;
                    error_d    = 1'b1;
                    err_code_d = 2'd1;
                    inv_d      = '0;
                end else begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // An exhausted budget aborts without charging another step.
                if (steps_q == CNT_W'(MAX_STEPS)) begin
                    state_d    = S_FIN;
                    error_d    = 1'b1;
                    err_code_d = 2'd3;
                    inv_d      = '0;
                end else begin
                    steps_d = steps_q + CNT_W'(1);
                    if (u_q == WIDTH'(1)) begin
                        state_d    = S_FIN;
                        done_d     = 1'b1;
                        err_code_d = 2'd0;
                        inv_d      = x1_q;
                    end else if (v_q == WIDTH'(1)) begin
                        state_d    = S_FIN;
                        done_d     = 1'b1;
                        err_code_d = 2'd0;
                        inv_d      = x2_q;
                    end else if ((u_q == '0) || (v_q == '0)) begin
                        state_d    = S_FIN;
                        error_d    = 1'b1;
                        err_code_d = 2'd3;
                        inv_d      = '0;
                    end else if (!u_q[0]) begin
                        u_d  = u_q >> 1;
                        x1_d = halve_mod(x1_q, pr_q);
                    end else if (!v_q[0]) begin
                        v_d  = v_q >> 1;
                        x2_d = halve_mod(x2_q, pr_q);
                    end else if (u_q >= v_q) begin
                        u_d  = u_q - v_q;
                        x1_d = sub_mod(x1_q, x2_q, pr_q);
                    end else begin
                        v_d  = v_q - u_q;
                        x2_d = sub_mod(x2_q, x1_q, pr_q);
                    end
                end
            end

            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            u_q        <= '0;
            v_q        <= '0;
            pr_q       <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            inv_q      <= '0;
            err_code_q <= 2'd0;
            steps_q    <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            u_q        <= u_d;
            v_q        <= v_d;
            pr_q       <= pr_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            inv_q      <= inv_d;
            err_code_q <= err_code_d;
            steps_q    <= steps_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign inv      = inv_q;
    assign err_code = err_code_q;
    assign steps    = steps_q;

endmodule

// File: tb/tb_mod_inv_bin.sv
// Self-checking bench for mod_inv_bin: 8-bit vector table with a result scoreboard,
// 256-bit held-start case, reset/timing corner sequences and 32-bit random trials.
module tb_mod_inv_bin;

    localparam int MAX8     = 36;
    localparam int N_RANDOM = 400;
    localparam logic [255:0] P256 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]   a8, p8, inv8;
    logic         start8, busy8, done8, error8;
    logic [1:0]   ec8;
    logic [5:0]   steps8;

    logic [31:0]  a32, p32, inv32;
    logic         start32, busy32, done32, error32;
    logic [1:0]   ec32;
    logic [7:0]   steps32;

    logic [255:0] a256, p256, inv256;
    logic         start256, busy256, done256, error256;
    logic [1:0]   ec256;
    logic [10:0]  steps256;

    mod_inv_bin #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .p(p8), .start(start8), .busy(busy8), .inv(inv8),
        .done(done8), .error(error8), .err_code(ec8), .steps(steps8)
    );

    mod_inv_bin #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .a(a32), .p(p32), .start(start32), .busy(busy32), .inv(inv32),
        .done(done32), .error(error32), .err_code(ec32), .steps(steps32)
    );

    mod_inv_bin #(.WIDTH(256)) dut256 (
        .clk(clk), .rst(rst), .a(a256), .p(p256), .start(start256), .busy(busy256),
        .inv(inv256), .done(done256), .error(error256), .err_code(ec256), .steps(steps256)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] p;
        logic [7:0] inv;
        logic [1:0] err;
        int         steps;
    } vec_t;

    typedef struct {
        logic [7:0] inv;
        logic [1:0] err;
        int         steps;
    } exp_t;

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    task automatic checkOutput(input string name, input logic [255:0] act,
                               input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic longint unsigned gcd(input longint unsigned x, input longint unsigned y);
        longint unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Every done/error pulse of the 8-bit engine consumes the oldest pending expectation.
    always @(negedge clk) begin : monitor8
        exp_t e;
        if (done8 || error8) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_result: done=%0b error=%0b inv=%0h, none pending",
                         done8, error8, inv8);
            end else begin
                e = sb.pop_front();
                checkOutput("inv", 256'(inv8), 256'(e.inv));
                checkOutput("err_code", 256'(ec8), 256'(e.err));
                checkOutput("done_error_kind", 256'({done8, error8}),
                            256'((e.err == 2'd0) ? 2'b10 : 2'b01));
                checkOutput("busy_during_pulse", 256'(busy8), 256'(1'b1));
                if (e.steps >= 0) begin
                    checkOutput("steps", 256'(steps8), 256'(e.steps));
                end else begin
                    tests_run++;
                    if ((steps8 == 6'd0) || (int'(steps8) > MAX8)) begin
                        tests_failed++;
                        $display("[TB] FAIL steps_range: got %0d, expected 1..%0d", steps8, MAX8);
                    end
                end
            end
        end
    end

    task automatic waitIdle8(input string name);
        int n = 0;
        while (busy8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy8) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s_timeout: busy still %0b after %0d cycles, expected 0", name, busy8, n);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int hold);
        exp_t e;
        e.inv   = v.inv;
        e.err   = v.err;
        e.steps = v.steps;
        sb.push_back(e);
        a8     = v.a;
        p8     = v.p;
        start8 = 1'b1;
        @(negedge clk);
        checkOutput("busy_after_accept", 256'(busy8), 256'(1'b1));
        a8 = 8'($urandom);
        p8 = 8'($urandom);
        for (int i = 1; i < hold; i++) @(negedge clk);
        start8 = 1'b0;
        waitIdle8("vector");
    endtask

    vec_t vecs [20];

    initial begin
        exp_t            e;
        int              ndone, nerr;
        logic [255:0]    inv_cap, exp256;
        logic [256:0]    t257;
        logic [10:0]     steps_cap;
        logic [511:0]    prod;
        longint unsigned ta, tp;
        bit              got;
        int              n;

        vecs = '{
            '{8'd2,   8'd251, 8'd126, 2'd0, -1},
            '{8'd0,   8'd7,   8'd0,   2'd1,  0},
            '{8'd3,   8'd10,  8'd0,   2'd2,  0},
            '{8'd6,   8'd9,   8'd0,   2'd3,  5},
            '{8'd1,   8'd7,   8'd1,   2'd0,  1},
            '{8'd2,   8'd7,   8'd4,   2'd0, -1},
            '{8'd3,   8'd7,   8'd5,   2'd0, -1},
            '{8'd4,   8'd7,   8'd2,   2'd0, -1},
            '{8'd5,   8'd7,   8'd3,   2'd0, -1},
            '{8'd6,   8'd7,   8'd6,   2'd0, -1},
            '{8'd7,   8'd7,   8'd0,   2'd1,  0},
            '{8'd0,   8'd1,   8'd0,   2'd2,  0},
            '{8'd5,   8'd2,   8'd0,   2'd2,  0},
            '{8'd255, 8'd255, 8'd0,   2'd1,  0},
            '{8'd3,   8'd9,   8'd0,   2'd3, -1},
            '{8'd128, 8'd255, 8'd2,   2'd0, -1},
            '{8'd250, 8'd251, 8'd250, 2'd0, -1},
            '{8'd2,   8'd3,   8'd2,   2'd0, -1},
            '{8'd200, 8'd255, 8'd0,   2'd3, -1},
            '{8'd77,  8'd251, 8'd163, 2'd0, -1}
        };

        rst = 1'b1;
        start8 = 1'b0; start32 = 1'b0; start256 = 1'b0;
        a8 = '0; p8 = '0; a32 = '0; p32 = '0; a256 = '0; p256 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        checkOutput("reset_busy", 256'(busy8), 256'(1'b0));
        checkOutput("reset_done_error", 256'({done8, error8}), 256'(2'b00));
        checkOutput("reset_inv", 256'(inv8), 256'(0));
        checkOutput("reset_err_code", 256'(ec8), 256'(0));
        checkOutput("reset_steps", 256'(steps8), 256'(0));
        checkOutput("reset_busy256", 256'(busy256), 256'(1'b0));
        @(negedge clk);

        for (int i = 0; i < 20; i++) applyStimulus(vecs[i], 1);

        // CHECK-stage error pulses two cycles after the accept edge.
        e = '{8'd0, 2'd1, 0};
        sb.push_back(e);
        a8 = 8'd0; p8 = 8'd7; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        checkOutput("chk_cycle_quiet", 256'({busy8, error8}), 256'(2'b10));
        @(negedge clk);
        checkOutput("chk_error_pulse", 256'(error8), 256'(1'b1));
        @(negedge clk);
        checkOutput("chk_after_pulse", 256'({busy8, error8}), 256'(2'b00));

        // a=1 finishes on the first RUN cycle: done three cycles after accept.
        e = '{8'd1, 2'd0, 1};
        sb.push_back(e);
        a8 = 8'd1; p8 = 8'd251; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        checkOutput("a1_no_early_done", 256'(done8), 256'(1'b0));
        @(negedge clk);
        checkOutput("a1_done_k3", 256'(done8), 256'(1'b1));
        @(negedge clk);
        checkOutput("a1_busy_drop", 256'(busy8), 256'(1'b0));

        // start edges while busy must not launch another operation.
        e = '{8'd250, 2'd0, -1};
        sb.push_back(e);
        a8 = 8'd250; p8 = 8'd251; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (3) begin
            @(negedge clk); start8 = 1'b1;
            @(negedge clk); start8 = 1'b0;
        end
        waitIdle8("toggle");
        repeat (4) @(negedge clk);

        // Held start on the 8-bit engine triggers exactly once.
        applyStimulus('{8'd2, 8'd7, 8'd4, 2'd0, -1}, 12);
        repeat (4) @(negedge clk);

        // Reset five cycles into RUN aborts silently; a fresh start then completes.
        a8 = 8'd77; p8 = 8'd251; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_busy", 256'(busy8), 256'(1'b0));
        checkOutput("rst_outputs", 256'({done8, error8, inv8, steps8}), 256'(0));
        repeat (3) @(negedge clk);
        checkOutput("rst_stays_idle", 256'({busy8, done8, error8}), 256'(0));
        rst = 1'b1; start8 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        @(negedge clk);
        checkOutput("rst_wins_start", 256'(busy8), 256'(1'b0));
        applyStimulus('{8'd77, 8'd251, 8'd163, 2'd0, -1}, 1);

        // 256-bit secp256k1 modulus with start held for 10 cycles.
        ndone = 0; nerr = 0; inv_cap = '0; steps_cap = '0;
        a256 = 256'd2; p256 = P256; start256 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin a256 = '0; p256 = '0; end
            if (i == 9) start256 = 1'b0;
            if (done256) begin ndone++; inv_cap = inv256; steps_cap = steps256; end
            if (error256) nerr++;
        end
        t257   = {1'b0, P256} + 257'd1;
        exp256 = t257[256:1];
        prod   = 512'(256'd2) * 512'(inv_cap);
        checkOutput("t2_done_count", 256'(ndone), 256'(1));
        checkOutput("t2_error_count", 256'(nerr), 256'(0));
        checkOutput("t2_inv", inv_cap, exp256);
        checkOutput("t2_product", prod % 512'(P256), 256'(1));
        checkOutput("t2_steps", 256'(steps_cap), 256'(2));
        checkOutput("t2_idle", 256'(busy256), 256'(1'b0));

        // Random 32-bit odd moduli with coprime operands.
        for (int t = 0; t < N_RANDOM; t++) begin
            tp = longint'($urandom) | 64'd1;
            if (tp < 3) tp = 3;
            do ta = longint'($urandom) % tp; while (ta == 0 || gcd(ta, tp) != 1);
            a32 = 32'(ta); p32 = 32'(tp); start32 = 1'b1;
            @(negedge clk);
            start32 = 1'b0;
            a32 = $urandom; p32 = $urandom;
            got = 1'b0; n = 0;
            while (!got && n < 200) begin
                @(negedge clk);
                n++;
                if (done32 || error32) got = 1'b1;
            end
            checkOutput("t6_done", 256'({done32, error32}), 256'(2'b10));
            checkOutput("t6_busy_with_done", 256'(busy32), 256'(1'b1));
            checkOutput("t6_product", 256'((ta * longint'(inv32)) % tp), 256'(1));
            @(negedge clk);
        end

        checkOutput("scoreboard_drained", 256'(sb.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
